mul_div_unit: RTL

- Iterative multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Executes MULT/MULTU/DIV/DIVU over 33 cycles and owns the architectural HI/LO registers; also serves MTHI/MTLO.
- Handshake is start/busy/done. The hazard unit stalls the pipeline on busy; abort is driven on pipeline flush.

---
 rtl/md_pkg.sv | 21 ++
 rtl/md_step.sv | 34 +++
 rtl/mul_div_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the divide-by-zero quotient pattern.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIV  = 2'd1,
    MD_MTHI = 2'd2,
    MD_MTLO = 2'd3
  } md_conf_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Wide enough to be sliced down to any supported operand width.
  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/md_step.sv
// One iteration of the shared multiply/divide datapath: a radix-2 add-shift
// step for MUL, or a single restoring trial-subtract step for DIV.
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  // MUL: acc = {partial product, remaining multiplier bits}; operand = multiplicand.
  // DIV: acc = {partial remainder, remaining dividend / quotient bits}; operand = divisor.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    // NOTE: every variable gets a value on every path, so no latch is inferred.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : '0)};
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    fits     = (trial >= {1'b0, operand});
    // When the trial fits, the true difference is below the divisor and so
    // fits in WIDTH bits; modular subtraction of the low bits is exact.
    diff     = trial[WIDTH-1:0] - operand;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (fits) acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else      acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; also serves
// MTHI/MTLO. One result bit per cycle, start/busy/done handshake with abort.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       MDConf,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state, state_nxt;
  md_conf_e           conf;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   operand;
  logic               is_div, neg_res, neg_rem, div0;
  logic [WIDTH-1:0]   in1_mag, in2_mag;
  logic               req, last_iter;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  assign conf      = md_conf_e'(MDConf);
  // A flushed instruction must not launch, so abort masks start in IDLE.
  assign req       = start && !abort && (state == ST_IDLE);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state != ST_IDLE);

  assign in1_mag = (Sign && in1[WIDTH-1]) ? -in1 : in1;
  assign in2_mag = (Sign && in2[WIDTH-1]) ? -in2 : in2;

  assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  // On divide-by-zero the remainder magnitude is the dividend magnitude, so
  // re-applying the dividend sign yields in1 exactly as supplied.
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign prod_fix = neg_res ? -acc : acc;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req && (conf == MD_MUL || conf == MD_DIV)) state_nxt = ST_CALC;
      ST_CALC: begin
        if (abort)          state_nxt = ST_IDLE;
        else if (last_iter) state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            case (conf)
              MD_MUL, MD_DIV: begin
                cnt     <= '0;
                is_div  <= (conf == MD_DIV);
                neg_res <= Sign && (in1[WIDTH-1] ^ in2[WIDTH-1]);
                neg_rem <= Sign && in1[WIDTH-1];
                div0    <= (in2 == '0);
                if (conf == MD_DIV) begin
                  acc     <= {{WIDTH{1'b0}}, in1_mag};
                  operand <= in2_mag;
                end else begin
                  acc     <= {{WIDTH{1'b0}}, in2_mag};
                  operand <= in1_mag;
                end
              end
              MD_MTHI: hi <= in1;
              MD_MTLO: lo <= in1;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        ST_FIX: begin
          if (!abort) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= div0 ? DIV0_QUOT[WIDTH-1:0] : quot_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
